// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_pkg
//  Description : Shared types and constants for the load/store unit: access
//                size encodings, FSM state type, word type and the access
//                legality check. LSU_SUBWORD_EN enables byte/half accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    typedef logic [31:0] word_t;

    // Returns 1 when the access cannot be performed (bad size or misaligned).
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] addr_lo);
`ifdef LSU_SUBWORD_EN
        case (size)
            SZ_BYTE: access_err = 1'b0;
            SZ_HALF: access_err = addr_lo[0];
            SZ_WORD: access_err = (addr_lo != 2'b00);
            default: access_err = 1'b1;
        endcase
`else
        access_err = (size != SZ_WORD) || (addr_lo != 2'b00);
`endif
    endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational lane handling. Extracts and sign/zero-extends
//                the addressed byte/half of a memory word for loads, and
//                merges store data into the addressed lane for sub-word
//                stores (little-endian). Without LSU_SUBWORD_EN only whole
//                words pass through.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0] size,
    input  logic       is_unsigned,
    input  logic [1:0] addr_lo,
    input  word_t      mem_word,
    input  word_t      wdata,
    output word_t      load_data,
    output word_t      store_word
);

`ifdef LSU_SUBWORD_EN
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_fill;

    // Lane select plus extension for loads; lane replacement for stores.
    always_comb begin
        w_byte     = mem_word[{addr_lo, 3'b000} +: 8];
        w_half     = mem_word[{addr_lo[1], 4'b0000} +: 16];
        w_fill     = 1'b0;
        load_data  = mem_word;
        store_word = wdata;
        case (size)
            SZ_BYTE: begin
                w_fill     = ~is_unsigned & w_byte[7];
                load_data  = {{24{w_fill}}, w_byte};
                store_word = mem_word;
                store_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                w_fill     = ~is_unsigned & w_half[15];
                load_data  = {{16{w_fill}}, w_half};
                store_word = mem_word;
                store_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            default: ;
        endcase
    end
`else
    // Only whole-word accesses reach memory; lane controls have no effect.
    logic w_unused_lane;
    assign w_unused_lane = ^{size, is_unsigned, addr_lo};
    assign load_data     = mem_word;
    assign store_word    = wdata;
`endif

endmodule : lsu_lane_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : CPU load/store unit in front of a word-wide data memory.
//                Handles byte/half/word loads with extension, word stores
//                and read-modify-write sub-word stores, and flags illegal or
//                misaligned accesses. Sub-word support is enabled by the
//                LSU_SUBWORD_EN macro; without it only aligned words are
//                legal.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       Wdata,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [31:0]       Rdata
);

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;

    logic              r_we;
    logic [1:0]        r_size;
    logic              r_unsigned;
    logic [ADDR_W-1:0] r_addr;
    word_t             r_wdata;
    logic              r_err;
    word_t             r_mem_word;

    logic              w_accept;
    logic              w_req_err;
    word_t             w_load_data;
    word_t             w_store_word;

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_req_err = access_err(req_size, req_addr[1:0]);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request fields latched on acceptance; memory word captured at end of RD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
            r_mem_word <= '0;
        end else begin
            if (w_accept) begin
                r_we       <= req_we;
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
                r_err      <= w_req_err;
            end
            if (r_state == RD) begin
                r_mem_word <= Rdata;
            end
        end
    end

    // Next-state logic: errors skip memory, sub-word stores read first.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_req_err) begin
                        w_next_state = RESP;
                    end else if (!req_we) begin
                        w_next_state = RD;
`ifdef LSU_SUBWORD_EN
                    end else if (req_size != SZ_WORD) begin
                        w_next_state = RD;
`endif
                    end else begin
                        w_next_state = WR;
                    end
                end
            end
`ifdef LSU_SUBWORD_EN
            RD:      w_next_state = r_we ? WR : RESP;
`else
            RD:      w_next_state = RESP;
`endif
            WR:      w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    lsu_lane_align u_lane_align (
        .size        (r_size),
        .is_unsigned (r_unsigned),
        .addr_lo     (r_addr[1:0]),
        .mem_word    (r_mem_word),
        .wdata       (r_wdata),
        .load_data   (w_load_data),
        .store_word  (w_store_word)
    );

    // Outputs decoded from the current state; everything idles at zero.
    always_comb begin
        req_ready  = (r_state == IDLE);
        MemRead    = (r_state == RD);
        MemWrite   = (r_state == WR);
        address    = '0;
        Wdata      = '0;
        resp_valid = (r_state == RESP);
        resp_err   = (r_state == RESP) && r_err;
        resp_rdata = '0;
        if ((r_state == RD) || (r_state == WR)) begin
            address = {r_addr[ADDR_W-1:2], 2'b00};
        end
        if (r_state == WR) begin
            Wdata = w_store_word;
        end
        if ((r_state == RESP) && !r_we && !r_err) begin
            resp_rdata = w_load_data;
        end
    end

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Directed self-checking bench for load_store_unit with a
//                small word-wide memory model. Expectations follow the
//                LSU_SUBWORD_EN setting of the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] Wdata;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Rdata;

    logic [31:0] mem [0:15];
    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int busy_cnt = 0;
    int resp_cnt = 0;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .address(address),
        .Wdata(Wdata), .MemWrite(MemWrite), .MemRead(MemRead), .Rdata(Rdata)
    );

    always #5 clk = ~clk;

    assign Rdata = MemRead ? mem[address[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (MemWrite) mem[address[5:2]] <= Wdata;
        if (MemRead) rd_cnt <= rd_cnt + 1;
        if (MemWrite) wr_cnt <= wr_cnt + 1;
        if (!req_ready) busy_cnt <= busy_cnt + 1;
        if (resp_valid) resp_cnt <= resp_cnt + 1;
    end

    // Called at a negedge: presents the request, waits for the accept edge and
    // reports the number of edges until resp_valid (0 on timeout).
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata,
                          output logic err, output logic rdy);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd;
        #1 rdy = req_ready;
        @(posedge clk);
        lat = 0; rdata = 32'hxxxx_xxxx; err = 1'bx;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1;
        @(negedge clk); @(negedge clk);
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", req_ready); end
        n_cmp++; if ({resp_valid, resp_err, MemRead, MemWrite} !== 4'b0000) begin n_bad++; $display("FAIL rst_ctrl: got %b want 0000", {resp_valid, resp_err, MemRead, MemWrite}); end
        n_cmp++; if ({address, Wdata, resp_rdata} !== 96'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", {address, Wdata, resp_rdata}); end
        req_valid = 1'b0;
    endtask

    task automatic test_first_accept();
        int lat; logic [31:0] rd; logic er, rdy;
        @(negedge clk);
        rst_n = 1'b1;
        do_req(1'b1, 2'b10, 1'b0, 32'h8, 32'h80FF7F01, lat, rd, er, rdy);
        n_cmp++; if (lat !== 2 || er !== 1'b0) begin n_bad++; $display("FAIL first_sw: got lat %0d err %b want lat 2 err 0", lat, er); end
        n_cmp++; if (mem[2] !== 32'h80FF7F01) begin n_bad++; $display("FAIL first_sw_mem: got %h want 80ff7f01", mem[2]); end
        @(negedge clk);
        do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h55AA55AA, lat, rd, er, rdy);
        @(negedge clk);
        do_req(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, lat, rd, er, rdy);
        n_cmp++; if (lat !== 2 || rd !== 32'h80FF7F01 || er !== 1'b0) begin n_bad++; $display("FAIL lw: got lat %0d data %h err %b want 2 80ff7f01 0", lat, rd, er); end
    endtask

    task automatic test_load_ext();
        int lat; logic [31:0] rd; logic er, rdy;
        logic [31:0] exp_d [4] = '{32'h0000007F, 32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF};
        logic [1:0]  szs   [4] = '{2'b00, 2'b00, 2'b00, 2'b01};
        logic        unss  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [31:0] adrs  [4] = '{32'h9, 32'hA, 32'hA, 32'hA};
        int r0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r0 = rd_cnt;
            do_req(1'b0, szs[i], unss[i], adrs[i], 32'h0, lat, rd, er, rdy);
`ifdef LSU_SUBWORD_EN
            n_cmp++; if (lat !== 2 || rd !== exp_d[i] || er !== 1'b0) begin n_bad++; $display("FAIL load_%0d: got lat %0d data %h err %b want 2 %h 0", i, lat, rd, er, exp_d[i]); end
            n_cmp++; if (rd_cnt - r0 !== 1) begin n_bad++; $display("FAIL load_rd_%0d: got %0d reads want 1", i, rd_cnt - r0); end
`else
            n_cmp++; if (lat !== 1 || rd !== 32'h0 || er !== 1'b1) begin n_bad++; $display("FAIL load_%0d: got lat %0d data %h err %b want 1 0 1 (ref %h)", i, lat, rd, er, exp_d[i]); end
            n_cmp++; if (rd_cnt - r0 !== 0) begin n_bad++; $display("FAIL load_rd_%0d: got %0d reads want 0", i, rd_cnt - r0); end
`endif
        end
    endtask

    task automatic test_rmw();
        int lat, r0, w0; logic [31:0] rd; logic er, rdy;
        @(negedge clk);
        do_req(1'b1, 2'b10, 1'b0, 32'hC, 32'h11223344, lat, rd, er, rdy);
        @(negedge clk);
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(1'b1, 2'b01, 1'b0, 32'hE, 32'h0000BEEF, lat, rd, er, rdy);
`ifdef LSU_SUBWORD_EN
        n_cmp++; if (lat !== 3 || er !== 1'b0 || rd !== 32'h0) begin n_bad++; $display("FAIL sh: got lat %0d err %b data %h want 3 0 0", lat, er, rd); end
        n_cmp++; if (mem[3] !== 32'hBEEF3344) begin n_bad++; $display("FAIL sh_mem: got %h want beef3344", mem[3]); end
        n_cmp++; if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin n_bad++; $display("FAIL sh_ops: got rd %0d wr %0d want 1 1", rd_cnt - r0, wr_cnt - w0); end
        @(negedge clk);
        do_req(1'b1, 2'b00, 1'b0, 32'hD, 32'h123456A5, lat, rd, er, rdy);
        n_cmp++; if (lat !== 3 || mem[3] !== 32'hBEEFA544) begin n_bad++; $display("FAIL sb_mem: got lat %0d mem %h want 3 beefa544", lat, mem[3]); end
`else
        n_cmp++; if (lat !== 1 || er !== 1'b1) begin n_bad++; $display("FAIL sh: got lat %0d err %b want 1 1", lat, er); end
        n_cmp++; if (mem[3] !== 32'h11223344) begin n_bad++; $display("FAIL sh_mem: got %h want 11223344", mem[3]); end
        n_cmp++; if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL sh_ops: got rd %0d wr %0d want 0 0", rd_cnt - r0, wr_cnt - w0); end
`endif
    endtask

    task automatic test_misaligned();
        int lat, r0, w0; logic [31:0] rd; logic er, rdy;
        logic [1:0]  szs  [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
        logic        wes  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] adrs [4] = '{32'h6, 32'h9, 32'h8, 32'hA};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            r0 = rd_cnt; w0 = wr_cnt;
            do_req(wes[i], szs[i], 1'b0, adrs[i], 32'hFFFFFFFF, lat, rd, er, rdy);
            n_cmp++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL err_%0d: got lat %0d err %b data %h want 1 1 0", i, lat, er, rd); end
            @(negedge clk);
            n_cmp++; if (rd_cnt - r0 !== 0 || wr_cnt - w0 !== 0) begin n_bad++; $display("FAIL err_ops_%0d: got rd %0d wr %0d want 0 0", i, rd_cnt - r0, wr_cnt - w0); end
        end
        n_cmp++; if (mem[1] !== 32'h55AA55AA) begin n_bad++; $display("FAIL err_mem: got %h want 55aa55aa", mem[1]); end
    endtask

    task automatic test_back_to_back();
        int lat, b0; logic [31:0] rd; logic er, rdy;
        @(negedge clk);
        b0 = busy_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, rdy);
        n_cmp++; if (lat !== 2 || er !== 1'b0) begin n_bad++; $display("FAIL b2b_sw: got lat %0d err %b want 2 0", lat, er); end
        @(negedge clk);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, rd, er, rdy);
        n_cmp++; if (rdy !== 1'b1 || lat !== 2 || rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL b2b_lw: got rdy %b lat %0d data %h want 1 2 deadbeef", rdy, lat, rd); end
        @(negedge clk);
        n_cmp++; if (busy_cnt - b0 !== 4 || req_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_busy: got %0d busy ready %b want 4 1", busy_cnt - b0, req_ready); end
    endtask

    task automatic test_reset_mid();
        int lat, c0; logic [31:0] rd; logic er, rdy, found;
        @(negedge clk);
        do_req(1'b1, 2'b10, 1'b0, 32'h14, 32'h13572468, lat, rd, er, rdy);
        @(negedge clk);
        c0 = resp_cnt;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h14; req_unsigned = 1'b0;
`ifdef LSU_SUBWORD_EN
        req_size = 2'b01; req_wdata = 32'h0000CAFE;
`else
        req_size = 2'b10; req_wdata = 32'h0BADF00D;
`endif
        @(posedge clk);
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (MemWrite === 1'b1) begin found = 1'b1; break; end
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL mid_wr_seen: got %b want 1", found); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (MemWrite !== 1'b0 || MemRead !== 1'b0 || req_ready !== 1'b1) begin n_bad++; $display("FAIL mid_rst_ctrl: got wr %b rd %b rdy %b want 0 0 1", MemWrite, MemRead, req_ready); end
        @(posedge clk); @(negedge clk);
        n_cmp++; if (resp_valid !== 1'b0 || resp_cnt !== c0) begin n_bad++; $display("FAIL mid_rst_resp: got valid %b count %0d want 0 %0d", resp_valid, resp_cnt, c0); end
        n_cmp++; if (mem[5] !== 32'h13572468) begin n_bad++; $display("FAIL mid_rst_mem: got %h want 13572468", mem[5]); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_load_ext();
        test_rmw();
        test_misaligned();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_load_store_unit
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width on both the CPU and memory sides.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  in  1  CPU access request.
REQ-005 SHALL have port req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0; ignored for stores.
REQ-009 SHALL have port req_addr  in  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata  out  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port resp_err  out  1  misaligned, illegal-size or unsupported access; valid with resp_valid.
REQ-014 SHALL have ports address (out, ADDR_W), Wdata (out, 32), MemWrite (out, 1), MemRead (out, 1) and Rdata (in, 32), forming the word-wide data-memory port.
REQ-015 The memory read path SHALL be combinational while MemRead=1; a write SHALL commit at the clk edge while MemWrite=1.

Function
REQ-016 The FSM SHALL have the states IDLE, RD, WR and RESP.
REQ-017 On acceptance, the unit SHALL latch we, size, unsigned, addr and wdata.
REQ-018 Transitions from IDLE SHALL be:
  - error -> RESP
  - load -> RD
  - word store -> WR
  - sub-word store -> RD.
REQ-019 Transitions from RD SHALL be: load -> RESP; store -> WR. Rdata SHALL be captured at the end of RD.
REQ-020 WR SHALL transition to RESP; RESP SHALL transition to IDLE.
REQ-021 MemRead SHALL be 1 only in RD and MemWrite SHALL be 1 only in WR, each for exactly one cycle.
REQ-022 address SHALL equal {latched addr[ADDR_W-1:2], 2'b00} during RD and WR, and 0 otherwise.
REQ-023 Latency from the accept edge to resp_valid SHALL be: load 2 cycles; word store 2; sub-word store 3; error 1.
REQ-024 Byte order SHALL be little-endian: byte lane = addr[1:0]; half lane = addr[1].
REQ-025 A load SHALL select its lane from the captured word and then sign- or zero-extend it to 32 bits.
REQ-026 A sub-word store SHALL write the captured word with only the target lane replaced by wdata[7:0] or wdata[15:0] (read-modify-write).
REQ-027 resp_err SHALL be 1, with no MemRead or MemWrite issued, for any of:
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - req_size=11.
REQ-028 Requests presented while req_ready=0 SHALL be ignored; there is no response backpressure.
REQ-029 A new request presented in the cycle after RESP (IDLE) SHALL be accepted; the minimum request spacing is therefore 2 cycles for errors.

Reset
REQ-030 While rst_n=0, the unit SHALL force state to IDLE, all outputs to 0 except req_ready=1, and all latched fields to 0.
REQ-031 Reset asserted mid-operation SHALL drop MemWrite and MemRead immediately and produce no resp_valid.
REQ-032 The first request SHALL be accepted on the first rising edge after rst_n rises.

Configuration
REQ-033 The macro LSU_SUBWORD_EN SHALL control sub-word support.
  - Defined: byte and half accesses behave as specified above.
  - Undefined: any req_size other than 10 SHALL complete as an error (resp_err=1, latency 1, no memory access), and the read-modify-write path SHALL be absent.

Structure
REQ-034 A shared package lsu_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the state enum and a 32-bit word type.
REQ-035 A combinational sub-module lsu_lane_align SHALL implement load extract/extend and store merge.

Verification
REQ-036 Setup: word at 0x8 = 0x80FF7F01. LB at 0x9 -> rdata 0x0000007F, err 0, resp_valid 2 cycles after accept.
REQ-037 Same word: LB at 0xA -> 0xFFFFFFFF; LBU at 0xA -> 0x000000FF; LH at 0xA -> 0xFFFF80FF.
REQ-038 Word 0x11223344 at 0xC: SH of 0x0000BEEF to 0xE -> memory 0xBEEF3344; one MemRead then one MemWrite; resp_valid 3 cycles after accept.
REQ-039 SW to 0x6 -> resp_err=1 one cycle after accept; MemRead and MemWrite never asserted; memory unchanged.
REQ-040 SW 0xDEADBEEF to 0x10, then LW from 0x10 accepted the cycle after RESP -> 0xDEADBEEF; req_ready low for exactly the busy cycles.
REQ-041 rst_n driven low during the WR cycle of an SH -> MemWrite low immediately; memory unchanged; no resp_valid; req_ready=1.
